// File: rtl/i2c_bridge_seq.sv
// Direction sequencer for the I2C bridge: follows START/address/data/ACK/STOP
// framing on the synchronized bus lines and decides which side owns SDA.
module i2c_bridge_seq #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m_scl_in,
  input  logic       m_sda_in,
  input  logic       s_sda_in,
  output logic       sda_dir,
  output logic       busy,
  output logic       rw,
  output logic [3:0] bit_cnt,
  output logic       start_pulse,
  output logic       stop_pulse,
  output logic       nack_pulse,
  output logic       timeout_pulse
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] scl_sync, msda_sync, ssda_sync;
  logic                   scl_d, msda_d;
  logic                   scl_s, msda_s, ssda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t      state, state_n;
  logic [3:0]  bit_n;
  logic        rw_n, nack_q, nack_n, dir_n;
  logic        start_n, stop_n, nackp_n, to_n;
  logic [15:0] to_cnt, cnt_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync  <= '1;
      msda_sync <= '1;
      ssda_sync <= '1;
      scl_d     <= 1'b1;
      msda_d    <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], m_scl_in};
      msda_sync <= {msda_sync[SYNC_STAGES-2:0], m_sda_in};
      ssda_sync <= {ssda_sync[SYNC_STAGES-2:0], s_sda_in};
      scl_d     <= scl_sync[SYNC_STAGES-1];
      msda_d    <= msda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign msda_s   = msda_sync[SYNC_STAGES-1];
  assign ssda_s   = ssda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // Slave-driven SDA would alias as bus conditions, so only look while master owns SDA.
  assign start_det = ~sda_dir & scl_s & scl_d & msda_d & ~msda_s;
  assign stop_det  = ~sda_dir & scl_s & scl_d & ~msda_d & msda_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      rw            <= 1'b0;
      nack_q        <= 1'b0;
      to_cnt        <= '0;
      sda_dir       <= 1'b0;
      busy          <= 1'b0;
      start_pulse   <= 1'b0;
      stop_pulse    <= 1'b0;
      nack_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_n;
      rw            <= rw_n;
      nack_q        <= nack_n;
      to_cnt        <= cnt_n;
      sda_dir       <= dir_n;
      busy          <= (state_n != S_IDLE);
      start_pulse   <= start_n;
      stop_pulse    <= stop_n;
      nack_pulse    <= nackp_n;
      timeout_pulse <= to_n;
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    rw_n    = rw;
    nack_n  = nack_q;
    start_n = 1'b0;
    stop_n  = 1'b0;
    nackp_n = 1'b0;
    to_n    = 1'b0;
    cnt_n   = (state == S_IDLE || scl_s) ? '0 : to_cnt + 16'd1;

    if (start_det) begin
      state_n = S_ADDR;
      bit_n   = '0;
      start_n = 1'b1;
    end else if (stop_det) begin
      state_n = S_IDLE;
      bit_n   = '0;
      stop_n  = 1'b1;
    end else if (state != S_IDLE && !scl_s && to_cnt == TO_LAST) begin
      state_n = S_IDLE;
      bit_n   = '0;
      to_n    = 1'b1;
      cnt_n   = '0;
    end else begin
      case (state)
        S_ADDR, S_WRITE, S_READ: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_n = bit_cnt + 4'd1;
            if (state == S_ADDR && bit_cnt == 4'd7) rw_n = msda_s;
          end
          if (scl_fall && bit_cnt == 4'd8) begin
            bit_n = '0;
            case (state)
              S_ADDR:  state_n = S_ADDR_ACK;
              S_WRITE: state_n = S_WRITE_ACK;
              default: state_n = S_READ_ACK;
            endcase
          end
        end
        S_ADDR_ACK, S_WRITE_ACK, S_READ_ACK: begin
          // The acknowledge is sampled on the first rise of the slot and acted on at the fall.
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd0) begin
              nack_n  = (state == S_READ_ACK) ? msda_s : ssda_s;
              nackp_n = nack_n;
            end
          end
          if (scl_fall && bit_cnt != 4'd0) begin
            bit_n = '0;
            if (nack_q)                   state_n = S_WAIT_STOP;
            else if (state == S_READ_ACK) state_n = S_READ;
            else if (state == S_WRITE_ACK) state_n = S_WRITE;
            else                          state_n = rw ? S_READ : S_WRITE;
          end
        end
        default: ;
      endcase
    end

    case (state_n)
      S_ADDR_ACK, S_WRITE_ACK, S_READ: dir_n = 1'b1;
      default:                         dir_n = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_i2c_bridge_seq.sv
// Scoreboard bench for i2c_bridge_seq: directed I2C frames, pulse events
// checked by a monitor, line-level state checked during the SCL high phase.
module tb_i2c_bridge_seq;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 100;

  logic       clk = 1'b0;
  logic       reset, m_scl_in, m_sda_in, s_sda_in;
  logic       sda_dir, busy, rw;
  logic [3:0] bit_cnt;
  logic       start_pulse, stop_pulse, nack_pulse, timeout_pulse;

  always #5 clk = ~clk;

  i2c_bridge_seq #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .m_scl_in(m_scl_in), .m_sda_in(m_sda_in),
    .s_sda_in(s_sda_in), .sda_dir(sda_dir), .busy(busy), .rw(rw), .bit_cnt(bit_cnt),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .nack_pulse(nack_pulse),
    .timeout_pulse(timeout_pulse)
  );

  typedef enum int {EV_START, EV_STOP, EV_NACK, EV_TIMEOUT} ev_t;
  typedef struct { ev_t kind; logic busy; } ev_s;

  ev_s exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic wait_clk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_t k, input logic b);
    ev_s e;
    e.kind = k;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input ev_t k);
    ev_s e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: got %s busy=%0b expected no pulse", k.name(), busy);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.busy !== busy) begin
        errors++;
        $display("FAIL event: got %s busy=%0b expected %s busy=%0b",
                 k.name(), busy, e.kind.name(), e.busy);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (start_pulse)   pop_cmp(EV_START);
      if (stop_pulse)    pop_cmp(EV_STOP);
      if (nack_pulse)    pop_cmp(EV_NACK);
      if (timeout_pulse) pop_cmp(EV_TIMEOUT);
    end
  end

  task automatic send_bit(input logic mb, input logic sb, input logic exp_dir,
                          input logic [3:0] exp_bc, input string nm);
    m_sda_in = mb;
    s_sda_in = sb;
    wait_clk(4);
    m_scl_in = 1'b1;
    wait_clk(6);
    chk({nm, "_dir"}, 16'(sda_dir), 16'(exp_dir));
    chk({nm, "_bitcnt"}, 16'(bit_cnt), 16'(exp_bc));
    wait_clk(2);
    m_scl_in = 1'b0;
    wait_clk(4);
  endtask

  task automatic start_cond();
    m_sda_in = 1'b1;
    s_sda_in = 1'b1;
    wait_clk(4);
    m_scl_in = 1'b1;
    wait_clk(8);
    m_sda_in = 1'b0;
    wait_clk(8);
    m_scl_in = 1'b0;
    wait_clk(4);
  endtask

  task automatic stop_cond();
    m_sda_in = 1'b0;
    s_sda_in = 1'b1;
    wait_clk(4);
    m_scl_in = 1'b1;
    wait_clk(8);
    m_sda_in = 1'b1;
    wait_clk(8);
  endtask

  // One byte plus its acknowledge slot; from_slave selects who drives the data bits.
  task automatic xfer(input logic [7:0] d, input logic from_slave, input logic ack,
                      input string nm);
    for (int i = 0; i < 8; i++) begin
      if (from_slave) send_bit(1'b1, d[7-i], 1'b1, 4'(i + 1), nm);
      else            send_bit(d[7-i], 1'b1, 1'b0, 4'(i + 1), nm);
    end
    if (ack) expect_ev(EV_NACK, 1'b1);
    if (from_slave) send_bit(ack, 1'b1, 1'b0, 4'd1, {nm, "_ack"});
    else            send_bit(1'b1, ack, 1'b1, 4'd1, {nm, "_ack"});
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    m_scl_in = 1'b1;
    m_sda_in = 1'b1;
    s_sda_in = 1'b1;
    wait_clk(3);
    chk("rst_dir", 16'(sda_dir), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_rw", 16'(rw), 16'h0);
    chk("rst_bitcnt", 16'(bit_cnt), 16'h0);
    chk("rst_pulses", 16'({start_pulse, stop_pulse, nack_pulse, timeout_pulse}), 16'h0);
    reset = 1'b1;
    wait_clk(20);
    chk("idle_busy", 16'(busy), 16'h0);

    // Write 0xA0, data 0x3C, both ACKed
    expect_ev(EV_START, 1'b1);
    start_cond();
    chk("wr_start_busy", 16'(busy), 16'h1);
    chk("wr_start_bitcnt", 16'(bit_cnt), 16'h0);
    xfer(8'hA0, 1'b0, 1'b0, "wr_addr");
    chk("wr_rw", 16'(rw), 16'h0);
    xfer(8'h3C, 1'b0, 1'b0, "wr_data");
    expect_ev(EV_STOP, 1'b0);
    stop_cond();
    chk("wr_end_busy", 16'(busy), 16'h0);
    chk("wr_end_dir", 16'(sda_dir), 16'h0);

    // Read 0xA1, two bytes, master ACK then NACK
    expect_ev(EV_START, 1'b1);
    start_cond();
    xfer(8'hA1, 1'b0, 1'b0, "rd_addr");
    chk("rd_rw", 16'(rw), 16'h1);
    xfer(8'h5A, 1'b1, 1'b0, "rd_b0");
    xfer(8'hC3, 1'b1, 1'b1, "rd_b1");
    chk("rd_nack_dir", 16'(sda_dir), 16'h0);
    expect_ev(EV_STOP, 1'b0);
    stop_cond();
    chk("rd_end_busy", 16'(busy), 16'h0);

    // Address NACKed by slave, then stray clocks stay in WAIT_STOP
    expect_ev(EV_START, 1'b1);
    start_cond();
    xfer(8'h42, 1'b0, 1'b1, "na_addr");
    chk("na_dir", 16'(sda_dir), 16'h0);
    send_bit(1'b0, 1'b1, 1'b0, 4'd0, "na_ws0");
    send_bit(1'b1, 1'b1, 1'b0, 4'd0, "na_ws1");
    send_bit(1'b0, 1'b1, 1'b0, 4'd0, "na_ws2");
    chk("na_busy", 16'(busy), 16'h1);
    expect_ev(EV_STOP, 1'b0);
    stop_cond();

    // Repeated START after first write byte, then a read address
    expect_ev(EV_START, 1'b1);
    start_cond();
    xfer(8'hA0, 1'b0, 1'b0, "rs_addr");
    xfer(8'h11, 1'b0, 1'b0, "rs_data");
    expect_ev(EV_START, 1'b1);
    start_cond();
    chk("rs_bitcnt", 16'(bit_cnt), 16'h0);
    chk("rs_busy", 16'(busy), 16'h1);
    xfer(8'hA1, 1'b0, 1'b0, "rs_raddr");
    chk("rs_rw", 16'(rw), 16'h1);
    xfer(8'h96, 1'b1, 1'b1, "rs_rdata");
    expect_ev(EV_STOP, 1'b0);
    stop_cond();

    // SCL held low mid-address
    expect_ev(EV_START, 1'b1);
    start_cond();
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 1'b0, 4'(i + 1), "to_bit");
    m_scl_in = 1'b1;
    wait_clk(8);
    m_scl_in = 1'b0;
    expect_ev(EV_TIMEOUT, 1'b0);
    n = 0;
    while (n < 200 && !timeout_pulse) begin
      wait_clk(1);
      n++;
    end
    chk("to_latency", 16'(n), 16'(TO + SYNC));
    chk("to_dir", 16'(sda_dir), 16'h0);
    chk("to_busy", 16'(busy), 16'h0);
    m_sda_in = 1'b1;
    wait_clk(4);
    m_scl_in = 1'b1;
    wait_clk(10);

    // Asynchronous reset while the slave owns SDA in READ
    expect_ev(EV_START, 1'b1);
    start_cond();
    xfer(8'hA1, 1'b0, 1'b0, "ar_addr");
    send_bit(1'b1, 1'b1, 1'b1, 4'd1, "ar_b0");
    send_bit(1'b1, 1'b0, 1'b1, 4'd2, "ar_b1");
    #2 reset = 1'b0;
    #1;
    chk("ar_dir", 16'(sda_dir), 16'h0);
    chk("ar_busy", 16'(busy), 16'h0);
    chk("ar_bitcnt", 16'(bit_cnt), 16'h0);
    chk("ar_rw", 16'(rw), 16'h0);
    m_scl_in = 1'b1;
    m_sda_in = 1'b1;
    s_sda_in = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(20);
    chk("ar_idle_busy", 16'(busy), 16'h0);

    chk("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_bridge_seq.md
# i2c_bridge_seq

Direction sequencer for the I2C bridge datapath. Watches the master-side SCL/SDA and the slave-side SDA, and tracks I2C framing: START, address byte, R/W bit, data bytes, ACK/NACK slots and STOP. From this it drives `sda_dir`, which tells the bridge which side currently owns SDA. It sits beside the bridge in the same clock domain; the bridge consumes `sda_dir`, and the status outputs go to debug/CSR logic.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on every line input (≥2).
- `TIMEOUT_CYCLES`, 50000: number of clk cycles SCL may stay low in a non-IDLE state before the frame is abandoned; 16-bit counter, valid range 1..65535.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `m_scl_in`  in  1  master-side SCL line level, asynchronous.
- `m_sda_in`  in  1  master-side SDA line level, asynchronous.
- `s_sda_in`  in  1  slave-side SDA line level, asynchronous.
- `sda_dir`  out  1  0 = master→slave, 1 = slave→master.
- `busy`  out  1  high in every state except IDLE.
- `rw`  out  1  R/W bit latched from the current address byte.
- `bit_cnt`  out  4  SCL rising edges counted in the current byte or ACK slot, 0..8.
- `start_pulse`  out  1  one-cycle strobe on START or repeated START.
- `stop_pulse`  out  1  one-cycle strobe on STOP.
- `nack_pulse`  out  1  one-cycle strobe when a NACK is sampled.
- `timeout_pulse`  out  1  one-cycle strobe when the SCL-low timeout expires.

## Operation
- **Synchronizers and edge detect**
  - Each input passes through `SYNC_STAGES` flops that reset to 1 (bus idle high).
  - One further delay flop per signal provides edge detection.
  - Edges are judged on synchronized values only.
- **START and STOP detection**
  - START: sync SDA falls while sync SCL is high in both the current and previous cycle.
  - STOP: sync SDA rises under the same SCL condition.
  - Detection is enabled only while `sda_dir`=0, because slave-driven data would otherwise alias as START/STOP.
- **States.** Transitions on "SCL fall" take effect on the synchronized falling edge, so SDA ownership only changes while SCL is low.
  - IDLE: dir=0. START → ADDR.
  - ADDR: dir=0.
    - Each SCL rise increments `bit_cnt`.
    - On the 8th rise, `rw` ← sync `m_sda_in`.
    - SCL fall with `bit_cnt`=8 → ADDR_ACK, `bit_cnt`←0.
  - ADDR_ACK: dir=1.
    - On SCL rise, sample sync `s_sda_in`: 1 → `nack_pulse`, then on SCL fall → WAIT_STOP.
    - 0 → on SCL fall → WRITE if `rw`=0, READ if `rw`=1.
  - WRITE: dir=0. 8 rises, then SCL fall → WRITE_ACK.
  - WRITE_ACK: dir=1. Slave ACK → WRITE; slave NACK → `nack_pulse`, then WAIT_STOP.
  - READ: dir=1. 8 rises, then SCL fall → READ_ACK.
  - READ_ACK: dir=0. Master SDA 0 at rise → READ; 1 → `nack_pulse`, then WAIT_STOP.
  - WAIT_STOP: dir=0. Waits for STOP or START.
- **Global transitions** (from any state where detection is enabled)
  - START → ADDR, `bit_cnt`←0, `start_pulse`.
  - STOP → IDLE, `stop_pulse`.
  - START/STOP take priority over the bit-count transitions in the same cycle.
- **Timeout**
  - The counter clears on every sync SCL high and in IDLE.
  - It increments while SCL is low outside IDLE.
  - Reaching `TIMEOUT_CYCLES` → IDLE, dir=0, `timeout_pulse`, counter cleared.
- `bit_cnt` saturates at 8: extra rises before the fall are ignored.

## Timing
- Reset values:
  - state IDLE.
  - `sda_dir`=0, `busy`=0, `rw`=0, `bit_cnt`=0.
  - All pulses 0; timeout counter 0; sync and delay flops 1.
- Reset assertion mid-frame returns to IDLE immediately (asynchronously) with the values above. After release, the next frame needs a fresh START.
- All outputs are registered.
- A line change is acted on `SYNC_STAGES`+1 cycles after the pin changes, so the `sda_dir` change follows the SCL falling edge by `SYNC_STAGES`+1 cycles (3 at default).
- Pulses are exactly one cycle wide.
- `busy` rises in the same cycle as `start_pulse` and falls in the same cycle as `stop_pulse` or `timeout_pulse`.
- Minimum SCL high/low phase is `SYNC_STAGES`+2 clk cycles; shorter phases are unsupported.

## Test plan
- Reset with lines idle → all outputs 0, IDLE; after release, no pulses while lines stay high.
- START, address 0x50 with W (0xA0), slave ACK, data 0x3C, slave ACK, STOP:
  - `start_pulse` once; `rw`=0.
  - `sda_dir`=1 only during the two ACK slots.
  - `stop_pulse` once; `busy` back to 0.
- START, address 0xA1 (R), slave ACK, read 2 bytes with master ACK then NACK, STOP:
  - `sda_dir`=1 across ADDR_ACK and both READ bytes, 0 in both READ_ACK slots.
  - `nack_pulse` on the second READ_ACK; STOP → IDLE.
- Address with slave NACK (s_sda high at the 9th rise):
  - `nack_pulse`; dir stays 0 after the SCL fall.
  - Further SCL clocks without START/STOP leave the state in WAIT_STOP.
- Repeated START after the first write byte → `start_pulse`, `bit_cnt`=0, ADDR; a following read address gives `rw`=1.
- Hold SCL low mid-byte for `TIMEOUT_CYCLES` (set to 100) → `timeout_pulse` at cycle 100, IDLE, dir=0.
- Assert `reset` low during READ → `sda_dir`=0 with no clock edge.
